// File: rtl/netlist_bist_ctrl_pkg.sv
// Shared definitions for the netlist BIST sequencer.
//   bist_state_e  : sequencer FSM states
//   LFSR_TAP_A/B  : default feedback taps of the 36-bit pattern LFSR (x^36 + x^25 + 1)
//   SIG_POLY_DEF  : default signature feedback polynomial
//   sig_step()    : one serial signature update, usable for any width up to 32 bits
package netlist_bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } bist_state_e;

    localparam int unsigned LFSR_TAP_A   = 35;
    localparam int unsigned LFSR_TAP_B   = 24;
    localparam logic [15:0] SIG_POLY_DEF = 16'h1021;
    localparam int unsigned SIG_W_MAX    = 32;

    // Shift left by one, and fold in the polynomial when the bit leaving the
    // register differs from the incoming netlist bit. Bits above w are masked off.
    function automatic logic [31:0] sig_step(input logic [31:0]   sig,
                                             input logic          b,
                                             input logic [31:0]   poly,
                                             input int unsigned   w);
        logic [31:0] mask;
        logic [31:0] shifted;
        logic        fb;
        mask    = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        fb      = sig[5'(w - 1)] ^ b;
        shifted = (sig << 1) & mask;
        return fb ? (shifted ^ (poly & mask)) : shifted;
    endfunction

endpackage

// File: rtl/netlist_bist_ctrl_if.sv
// Bus between the test/config side and the BIST sequencer.
//   master : test/config logic and netlist (drives start, abort, golden_sig_i, dut_out_i)
//   slave  : netlist_bist_ctrl (drives pattern_o, busy, done, pass, signature, pat_count)
interface netlist_bist_ctrl_if #(
    parameter int IN_W  = 36,
    parameter int SIG_W = 16,
    parameter int CNT_W = 9
);
    logic              start;
    logic              abort;
    logic [SIG_W-1:0]  golden_sig_i;
    logic              dut_out_i;
    logic [IN_W-1:0]   pattern_o;
    logic              busy;
    logic              done;
    logic              pass;
    logic [SIG_W-1:0]  signature;
    logic [CNT_W-1:0]  pat_count;

    modport master (
        output start, abort, golden_sig_i, dut_out_i,
        input  pattern_o, busy, done, pass, signature, pat_count
    );

    modport slave (
        input  start, abort, golden_sig_i, dut_out_i,
        output pattern_o, busy, done, pass, signature, pat_count
    );
endinterface

// File: rtl/netlist_bist_ctrl_lfsr.sv
// Pattern generator: Fibonacci LFSR shifting left, feedback = q[TAP_A] ^ q[TAP_B].
//   clk, rst : clock, async active-high reset (state -> 0)
//   load_i   : load SEED (priority over en_i)
//   en_i     : advance one step
//   state_o  : current pattern
module bist_lfsr
    import netlist_bist_pkg::*;
#(
    parameter int              IN_W  = 36,
    parameter logic [IN_W-1:0] SEED  = {{(IN_W-1){1'b0}}, 1'b1},
    parameter int unsigned     TAP_A = LFSR_TAP_A,
    parameter int unsigned     TAP_B = LFSR_TAP_B
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            en_i,
    output logic [IN_W-1:0] state_o
);
    logic [IN_W-1:0] state_q;
    logic [IN_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = SEED;
        end else if (en_i) begin
            state_d = {state_q[IN_W-2:0], state_q[TAP_A] ^ state_q[TAP_B]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
endmodule

// File: rtl/netlist_bist_ctrl.sv
// BIST sequencer for a single-output combinational netlist.
// Applies NUM_PATTERNS LFSR patterns, holds each SETTLE_CYCLES cycles, captures the
// netlist output into a serial signature and compares it with a golden value.
//   clk, rst : clock, async active-high reset
//   bus      : netlist_bist_ctrl_if.slave (start/abort/golden/dut_out in,
//              pattern/busy/done/pass/signature/pat_count out)
//
//   state   | meaning
//   IDLE    | waiting for start, results of an aborted run held for debug
//   SETTLE  | pattern applied, waiting for the netlist to settle
//   CAPTURE | one cycle: fold output bit into signature, advance pattern
//   DONE    | run finished, pass/signature/pat_count held until start or abort
module netlist_bist_ctrl
    import netlist_bist_pkg::*;
#(
    parameter int               IN_W          = 36,
    parameter logic [IN_W-1:0]  SEED          = {{(IN_W-1){1'b0}}, 1'b1},
    parameter int               NUM_PATTERNS  = 256,
    parameter int               SETTLE_CYCLES = 2,
    parameter int               SIG_W         = 16,
    parameter logic [SIG_W-1:0] SIG_POLY      = SIG_W'(SIG_POLY_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    netlist_bist_ctrl_if.slave bus
);
    localparam int CW = $clog2(NUM_PATTERNS + 1);
    // Counter runs up to SETTLE_CYCLES in the last SETTLE cycle, so size for that.
    localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    if (SEED == '0) begin : g_bad_seed
        $fatal(1, "netlist_bist_ctrl: SEED must be nonzero");
    end
    if (NUM_PATTERNS < 1) begin : g_bad_np
        $fatal(1, "netlist_bist_ctrl: NUM_PATTERNS must be >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_sc
        $fatal(1, "netlist_bist_ctrl: SETTLE_CYCLES must be >= 1");
    end
    if (SIG_W > int'(SIG_W_MAX) || SIG_W < 2) begin : g_bad_sigw
        $fatal(1, "netlist_bist_ctrl: SIG_W out of range");
    end

    bist_state_e      state_q;
    logic [SW-1:0]    settle_q;
    logic [CW-1:0]    cnt_q;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             lfsr_load;
    logic             lfsr_en;
    logic [IN_W-1:0]  pattern;

    assign sig_d = SIG_W'(sig_step(32'(sig_q), bus.dut_out_i, 32'(SIG_POLY), SIG_W));

    // The LFSR register lives in the sub-module; its load/advance mirror the FSM's
    // start and capture transitions, and abort freezes it for debug.
    assign lfsr_load = ((state_q == IDLE) || (state_q == DONE)) && bus.start && !bus.abort;
    assign lfsr_en   = (state_q == CAPTURE) && !bus.abort;

    bist_lfsr #(
        .IN_W  (IN_W),
        .SEED  (SEED),
        .TAP_A (LFSR_TAP_A),
        .TAP_B (LFSR_TAP_B)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (lfsr_load),
        .en_i    (lfsr_en),
        .state_o (pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            cnt_q    <= '0;
            sig_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else if (bus.abort) begin
            // signature, pat_count and settle counter intentionally hold
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q  <= SETTLE;
                        settle_q <= '0;
                        cnt_q    <= '0;
                        sig_q    <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                    end
                end
                SETTLE: begin
                    settle_q <= settle_q + 1'b1;
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    sig_q    <= sig_d;
                    cnt_q    <= cnt_q + 1'b1;
                    settle_q <= '0;
                    if (cnt_q == CW'(NUM_PATTERNS - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (sig_d == bus.golden_sig_i);
                    end else begin
                        state_q <= SETTLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pattern_o = pattern;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;
    assign bus.pat_count = cnt_q;
endmodule

// File: tb/tb_netlist_bist_ctrl.sv
module tb_netlist_bist_ctrl;
    localparam int          IN_W    = 36;
    localparam int          SIG_W   = 16;
    localparam int          NP      = 4;
    localparam int          SC      = 2;
    localparam int          CW      = $clog2(NP + 1);
    localparam logic [35:0] SEED    = 36'h1;
    localparam logic [15:0] POLY    = 16'h1021;
    localparam int          RUN_CYC = NP * (SC + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    netlist_bist_ctrl_if #(.IN_W(IN_W), .SIG_W(SIG_W), .CNT_W(CW)) bif ();

    netlist_bist_ctrl #(
        .IN_W          (IN_W),
        .SEED          (SEED),
        .NUM_PATTERNS  (NP),
        .SETTLE_CYCLES (SC),
        .SIG_W         (SIG_W),
        .SIG_POLY      (POLY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Netlist stand-in: constant 0, constant 1, or parity of a masked pattern.
    int          md = 0;
    logic [35:0] nmask = '0;
    assign bif.dut_out_i = (md == 0) ? 1'b0 : (md == 1) ? 1'b1 : ^(bif.pattern_o & nmask);

    typedef struct {
        logic [15:0] sig;
        bit          ps;
    } exp_t;
    exp_t q[$];

    int n_pass = 0;
    int n_tot  = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endfunction

    // x^36 + x^25 + 1, shifting left
    function automatic logic [35:0] lfsr_next(logic [35:0] p);
        return {p[34:0], p[35] ^ p[24]};
    endfunction

    // Reference: walk the pattern list and fold each response bit into a CRC-style register.
    function automatic logic [15:0] model_sig(logic [35:0] m, int mode);
        logic [35:0] p;
        logic [15:0] s;
        logic        b;
        p = SEED;
        s = '0;
        for (int k = 0; k < NP; k++) begin
            b = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : ^(p & m);
            s = {s[14:0], 1'b0} ^ ((s[15] ^ b) ? POLY : 16'h0);
            p = lfsr_next(p);
        end
        return s;
    endfunction

    task automatic push_model();
        logic [15:0] s;
        s = model_sig(nmask, md);
        q.push_back('{s, (s == bif.golden_sig_i)});
    endtask

    task automatic start_pulse();
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
    endtask

    task automatic wait_done(string nm);
        int k = 0;
        while (!bif.done && k < RUN_CYC + 10) begin
            @(negedge clk);
            k++;
        end
        chk(nm, bif.done, 1);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_pattern"}, bif.pattern_o, 0);
        chk({tag, "_busy"}, bif.busy, 0);
        chk({tag, "_done"}, bif.done, 0);
        chk({tag, "_pass"}, bif.pass, 0);
        chk({tag, "_signature"}, bif.signature, 0);
        chk({tag, "_pat_count"}, bif.pat_count, 0);
    endtask

    // Monitor: checks pattern/pat_count every busy cycle, and run results on done rising.
    int          bcnt = 0;
    logic        busy_prev = 1'b0;
    logic        done_prev = 1'b0;
    logic [35:0] pexp = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bif.busy) begin
                if (!busy_prev) begin
                    bcnt = 1;
                    pexp = SEED;
                end else begin
                    bcnt++;
                    if ((bcnt - 1) % (SC + 1) == 0) pexp = lfsr_next(pexp);
                end
                chk("run_pattern", bif.pattern_o, pexp);
                chk("run_pat_count", bif.pat_count, (bcnt - 1) / (SC + 1));
            end
            if (!rst && bif.done && !done_prev) begin
                if (q.size() == 0) begin
                    n_tot++;
                    $display("FAIL unexpected_done: no expected result queued");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_signature", bif.signature, e.sig);
                    chk("done_pass", bif.pass, e.ps);
                    chk("done_pat_count", bif.pat_count, NP);
                    chk("done_latency", bcnt, RUN_CYC);
                    chk("done_busy_low", bif.busy, 0);
                end
            end
            busy_prev = bif.busy;
            done_prev = bif.done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] sv_pat;
        logic [15:0] sv_sig;
        logic [CW-1:0] sv_cnt;
        rst = 1'b1;
        bif.start = 1'b0;
        bif.abort = 1'b0;
        bif.golden_sig_i = '0;
        #22;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", bif.busy, 0);

        // dut_out = 0, golden 0
        md = 0;
        bif.golden_sig_i = 16'h0000;
        q.push_back('{16'h0000, 1'b1});
        start_pulse();
        wait_done("t1_done_timeout");

        // dut_out = 1: known signature, then back-to-back with wrong golden
        md = 1;
        bif.golden_sig_i = 16'hF1EF;
        q.push_back('{16'hF1EF, 1'b1});
        start_pulse();
        chk("restart_from_done_done_low", bif.done, 0);
        chk("restart_from_done_busy", bif.busy, 1);
        wait_done("t2_done_timeout");
        bif.golden_sig_i = 16'hF1EE;
        q.push_back('{16'hF1EF, 1'b0});
        start_pulse();
        chk("b2b_done_low", bif.done, 0);
        wait_done("t2b_done_timeout");

        // abort from DONE
        sv_sig = bif.signature;
        bif.abort = 1'b1;
        @(negedge clk);
        bif.abort = 1'b0;
        chk("abort_done_done", bif.done, 0);
        chk("abort_done_pass", bif.pass, 0);
        chk("abort_done_sig_hold", bif.signature, sv_sig);

        // abort mid-run on cycle 5
        md = 1;
        start_pulse();
        repeat (3) @(negedge clk);
        sv_pat = bif.pattern_o;
        sv_sig = bif.signature;
        sv_cnt = bif.pat_count;
        bif.abort = 1'b1;
        @(negedge clk);
        bif.abort = 1'b0;
        chk("abort_busy", bif.busy, 0);
        chk("abort_done", bif.done, 0);
        chk("abort_pattern_hold", bif.pattern_o, sv_pat);
        chk("abort_sig_hold", bif.signature, sv_sig);
        chk("abort_cnt_hold", bif.pat_count, sv_cnt);
        @(negedge clk);
        chk("abort_stays_idle", bif.busy, 0);
        md = 2;
        nmask = {$urandom, $urandom};
        bif.golden_sig_i = 16'(model_sig(nmask, md));
        push_model();
        start_pulse();
        wait_done("t3_restart_timeout");

        // start pulsed mid-run is ignored
        md = 1;
        bif.golden_sig_i = 16'h1234;
        push_model();
        start_pulse();
        repeat (4) @(negedge clk);
        start_pulse();
        wait_done("t4_done_timeout");
        bif.abort = 1'b1;
        @(negedge clk);
        bif.abort = 1'b0;
        bif.start = 1'b1;
        bif.abort = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        bif.abort = 1'b0;
        chk("start_abort_busy", bif.busy, 0);
        chk("start_abort_done", bif.done, 0);
        @(negedge clk);
        chk("start_abort_idle", bif.busy, 0);

        // async reset during SETTLE
        start_pulse();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("post_rst_idle");

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : 2;
            nmask = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) bif.golden_sig_i = 16'(model_sig(nmask, md));
            else bif.golden_sig_i = 16'($urandom);
            push_model();
            start_pulse();
            wait_done("rand_done_timeout");
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
